// File: rtl/controller_pkg.sv
// Shared types and constants for the serial game-controller poller.
package controller_pkg;

  // Poll sequencer states; IDLE must stay encoded as zero.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_CLK_LO = 3'd4,
    ST_COMMIT = 3'd5
  } poll_state_e;

  localparam int BUTTONS_NES  = 8;
  localparam int BUTTONS_SNES = 16;

  // NES bit positions within a pad slice (first bit shifted lands in bit 0).
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // SNES bit positions within a pad slice.
  localparam int SNES_B     = 0;
  localparam int SNES_Y     = 1;
  localparam int SNES_SEL   = 2;
  localparam int SNES_START = 3;
  localparam int SNES_UP    = 4;
  localparam int SNES_DOWN  = 5;
  localparam int SNES_LEFT  = 6;
  localparam int SNES_RIGHT = 7;
  localparam int SNES_A     = 8;
  localparam int SNES_X     = 9;
  localparam int SNES_L     = 10;
  localparam int SNES_R     = 11;

endpackage

// File: rtl/controller_tick_gen_m.sv
// Divides cpu_clk into ticks: tick_o pulses for one cycle every CLK_DIV cycles.
// clear_i restarts the count so the first tick lands CLK_DIV cycles later.
module controller_tick_gen_m #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

  // Next count: clear wins, otherwise wrap on tick.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_controller_poller_m.sv
// N-channel NES/SNES pad poller. One start_fetch runs a latch + shift sequence on
// all pads in parallel and commits every channel on the same edge.
// Handshake: start_fetch is a 1-cycle request, accepted only when busy is low; a
// request while busy is dropped and flagged by overrun in the same cycle. done
// pulses for one cycle together with the new buttons_out/pressed_out/connected.
module multi_controller_poller_m
  import controller_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int BUTTONS         = 8,
  parameter int CLK_DIV         = 4,
  parameter int LATCH_TICKS     = 2
) (
  input  logic                               cpu_clk,
  input  logic                               rst,
  input  logic                               start_fetch,
  output logic                               controller_clk,
  output logic                               controller_latch,
  input  logic [NUM_CONTROLLERS-1:0]         data_in_B,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0] buttons_out,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0] pressed_out,
  output logic [NUM_CONTROLLERS-1:0]         connected,
  output logic                               busy,
  output logic                               done,
  output logic                               overrun,
  output logic [2:0]                         dbg_state_o
);

  localparam int NB = NUM_CONTROLLERS * BUTTONS;
  localparam int BW = $clog2(BUTTONS);
  localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

  poll_state_e    state_q, state_d;
  logic [LW-1:0]  lt_q, lt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           accept, sample_en, commit_en, tick;
  logic [NB-1:0]  buttons_q, pressed_q, new_btn;
  logic [NUM_CONTROLLERS-1:0] conn_q, pad_ok;
  logic           done_q;

  controller_tick_gen_m #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (cpu_clk),
    .rst_i   (rst),
    .clear_i (accept),
    .tick_o  (tick)
  );

  // Sequencer next state: latch ticks, settle, then clock pulses until all bits sampled.
  always_comb begin
    state_d   = state_q;
    lt_d      = lt_q;
    bit_d     = bit_q;
    accept    = 1'b0;
    sample_en = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_fetch) begin
          accept  = 1'b1;
          state_d = ST_LATCH;
          lt_d    = '0;
          bit_d   = '0;
        end
      end
      ST_LATCH: begin
        if (tick) begin
          if (lt_q == LW'(LATCH_TICKS - 1)) state_d = ST_SETTLE;
          else                              lt_d    = lt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tick) begin
          sample_en = 1'b1;
          bit_d     = BW'(1);
          state_d   = ST_CLK_HI;
        end
      end
      ST_CLK_HI: begin
        if (tick) state_d = ST_CLK_LO;
      end
      ST_CLK_LO: begin
        if (tick) begin
          sample_en = 1'b1;
          if (bit_q == BW'(BUTTONS - 1)) state_d = ST_COMMIT;
          else begin
            bit_d   = bit_q + 1'b1;
            state_d = ST_CLK_HI;
          end
        end
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lt_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      lt_q    <= lt_d;
      bit_q   <= bit_d;
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign overrun          = start_fetch && busy;
  assign controller_latch = (state_q == ST_LATCH);
  assign controller_clk   = (state_q == ST_CLK_HI);
  assign dbg_state_o      = state_q;

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_ch
    logic [1:0]         sync_q;
    logic [BUTTONS-1:0] shift_q;

    // Synchronise the pad line, then shift the inverted bit in from the top so the
    // first bit read ends up in bit 0.
    always_ff @(posedge cpu_clk) begin
      if (rst) begin
        sync_q  <= 2'b11;
        shift_q <= '0;
      end else begin
        sync_q <= {sync_q[0], data_in_B[k]};
        if (sample_en) shift_q <= {~sync_q[1], shift_q[BUTTONS-1:1]};
      end
    end

    // A line stuck low reads as every button pressed: treat as unplugged.
    assign pad_ok[k]                      = ~&shift_q;
    assign new_btn[k*BUTTONS +: BUTTONS]  = pad_ok[k] ? shift_q : '0;
  end

  // Atomic commit of all channels plus edge detection against the previous commit.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      buttons_q <= '0;
      pressed_q <= '0;
      conn_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit_en;
      if (commit_en) begin
        buttons_q <= new_btn;
        pressed_q <= new_btn & ~buttons_q;
        conn_q    <= pad_ok;
      end
    end
  end

  assign buttons_out = buttons_q;
  assign pressed_out = pressed_q;
  assign connected   = conn_q;
  assign done        = done_q;

endmodule

// File: tb/tb_multi_controller_poller_m.sv
// Directed bench for the controller poller: an NES (8-bit) and an SNES (16-bit)
// instance driven by behavioural pads, with a queue of expected commit results.
module tb_multi_controller_poller_m;

  logic cpu_clk = 1'b0;
  logic rst     = 1'b1;

  // NES instance signals
  logic        start_a = 1'b0;
  logic        clk_a, latch_a, busy_a, done_a, ovr_a;
  logic [1:0]  din_a, conn_a;
  logic [15:0] btn_a, prs_a;
  logic [2:0]  dbg_a;

  // SNES instance signals
  logic        start_s = 1'b0;
  logic        clk_s, latch_s, busy_s, done_s, ovr_s;
  logic [1:0]  din_s, conn_s;
  logic [31:0] btn_s, prs_s;
  logic [2:0]  dbg_s;

  // Pad contents (active-low raw words) and pad shift models
  logic [7:0]  raw_a0 = 8'hFF, raw_a1 = 8'hFF, sr_a0 = 8'hFF, sr_a1 = 8'hFF;
  logic [15:0] raw_s0 = 16'hFFFF, raw_s1 = 16'hFFFF, sr_s0 = 16'hFFFF, sr_s1 = 16'hFFFF;
  logic        pclk_a = 1'b0, pclk_s = 1'b0, tie1 = 1'b0;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] prs_q[$];
  logic [1:0]  conn_q[$];
  logic [15:0] model_a = '0;
  logic [31:0] model_s = '0;
  int n_cmp = 0;
  int n_err = 0;

  // Pulse monitors for the NES instance, cleared when a poll is accepted
  int latch_cnt = 0, clkp_cnt = 0, done_cnt = 0;
  logic mclk = 1'b0;

  multi_controller_poller_m #(.NUM_CONTROLLERS(2), .BUTTONS(8), .CLK_DIV(4), .LATCH_TICKS(2)) dut_a (
    .cpu_clk(cpu_clk), .rst(rst), .start_fetch(start_a),
    .controller_clk(clk_a), .controller_latch(latch_a), .data_in_B(din_a),
    .buttons_out(btn_a), .pressed_out(prs_a), .connected(conn_a),
    .busy(busy_a), .done(done_a), .overrun(ovr_a), .dbg_state_o(dbg_a));

  multi_controller_poller_m #(.NUM_CONTROLLERS(2), .BUTTONS(16), .CLK_DIV(4), .LATCH_TICKS(2)) dut_s (
    .cpu_clk(cpu_clk), .rst(rst), .start_fetch(start_s),
    .controller_clk(clk_s), .controller_latch(latch_s), .data_in_B(din_s),
    .buttons_out(btn_s), .pressed_out(prs_s), .connected(conn_s),
    .busy(busy_s), .done(done_s), .overrun(ovr_s), .dbg_state_o(dbg_s));

  // Clock
  always #5 cpu_clk = ~cpu_clk;

  // Pads: load while latch is high, shift on each controller_clk rising edge.
  always @(posedge cpu_clk) begin
    pclk_a <= clk_a;
    pclk_s <= clk_s;
    if (latch_a) begin
      sr_a0 <= raw_a0;
      sr_a1 <= raw_a1;
    end else if (clk_a && !pclk_a) begin
      sr_a0 <= {1'b1, sr_a0[7:1]};
      sr_a1 <= {1'b1, sr_a1[7:1]};
    end
    if (latch_s) begin
      sr_s0 <= raw_s0;
      sr_s1 <= raw_s1;
    end else if (clk_s && !pclk_s) begin
      sr_s0 <= {1'b1, sr_s0[15:1]};
      sr_s1 <= {1'b1, sr_s1[15:1]};
    end
  end

  assign din_a = {tie1 ? 1'b0 : sr_a1[0], sr_a0[0]};
  assign din_s = {sr_s1[0], sr_s0[0]};

  // Count latch-high cycles, controller_clk pulses and done pulses per poll.
  always @(posedge cpu_clk) begin
    mclk <= clk_a;
    if (start_a && !busy_a) begin
      latch_cnt <= 0;
      clkp_cnt  <= 0;
      done_cnt  <= 0;
    end else begin
      if (latch_a)         latch_cnt <= latch_cnt + 1;
      if (clk_a && !mclk)  clkp_cnt  <= clkp_cnt + 1;
      if (done_a)          done_cnt  <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pad decode: {connected, pressed word}
  function automatic logic [8:0] exp8(input logic [7:0] raw, input bit tied);
    if (tied || raw == 8'h00) return 9'h000;
    return {1'b1, ~raw};
  endfunction

  function automatic logic [16:0] exp16(input logic [15:0] raw);
    if (raw == 16'h0000) return 17'h0;
    return {1'b1, ~raw};
  endfunction

  task automatic pop_and_check(input logic [31:0] b, input logic [31:0] p, input logic [1:0] c);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check("buttons_out", b, exp_q.pop_front());
      check("pressed_out", p, prs_q.pop_front());
      check("connected", 32'(c), 32'(conn_q.pop_front()));
    end
  endtask

  // One NES poll; ovr_at/rst_at inject a request or a reset at that cycle (0 = none).
  task automatic poll_a(input logic [7:0] r0, input logic [7:0] r1, input bit tie,
                        input int ovr_at, input int rst_at);
    logic [8:0]  p0, p1;
    logic [15:0] nb;
    int dc;
    bit aborted;
    raw_a0 = r0;
    raw_a1 = r1;
    tie1   = tie;
    p0 = exp8(r0, 1'b0);
    p1 = exp8(r1, tie);
    nb = {p1[7:0], p0[7:0]};
    if (rst_at == 0) begin
      exp_q.push_back({16'h0, nb});
      prs_q.push_back({16'h0, nb & ~model_a});
      conn_q.push_back({p1[8], p0[8]});
      model_a = nb;
    end
    @(negedge cpu_clk) start_a = 1'b1;
    @(posedge cpu_clk); #1;
    start_a = 1'b0;
    check("busy_after_accept", 32'(busy_a), 32'd1);
    dc = 0;
    aborted = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == ovr_at) begin
        start_a = 1'b1;
        #1;
        check("overrun_pulse", 32'(ovr_a), 32'd1);
      end
      if (n == rst_at) rst = 1'b1;
      @(posedge cpu_clk); #1;
      start_a = 1'b0;
      if (rst) begin
        aborted = 1'b1;
        break;
      end
      if (done_a) begin
        dc = n;
        break;
      end
    end
    if (aborted) begin
      check("rst_ctrl_clk", 32'(clk_a), 32'd0);
      check("rst_latch", 32'(latch_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_buttons", 32'(btn_a), 32'd0);
      check("rst_pressed", 32'(prs_a), 32'd0);
      check("rst_connected", 32'(conn_a), 32'd0);
      rst = 1'b0;
      model_a = '0;
      repeat (2) @(posedge cpu_clk);
      #1;
      return;
    end
    check("done_cycle", 32'(dc), 32'd69);
    pop_and_check({16'h0, btn_a}, {16'h0, prs_a}, conn_a);
    check("busy_after_done", 32'(busy_a), 32'd0);
    repeat (3) @(posedge cpu_clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("latch_cycles", 32'(latch_cnt), 32'd8);
    check("clk_pulses", 32'(clkp_cnt), 32'd7);
    check("idle_no_restart", 32'(busy_a), 32'd0);
  endtask

  // One SNES poll on the 16-bit instance.
  task automatic poll_s(input logic [15:0] r0, input logic [15:0] r1);
    logic [16:0] p0, p1;
    logic [31:0] nb;
    int dc;
    raw_s0 = r0;
    raw_s1 = r1;
    p0 = exp16(r0);
    p1 = exp16(r1);
    nb = {p1[15:0], p0[15:0]};
    exp_q.push_back(nb);
    prs_q.push_back(nb & ~model_s);
    conn_q.push_back({p1[16], p0[16]});
    model_s = nb;
    @(negedge cpu_clk) start_s = 1'b1;
    @(posedge cpu_clk); #1;
    start_s = 1'b0;
    dc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge cpu_clk); #1;
      if (done_s) begin
        dc = n;
        break;
      end
    end
    check("snes_done_cycle", 32'(dc), 32'd133);
    pop_and_check(btn_s, prs_s, conn_s);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("reset_buttons", 32'(btn_a), 32'd0);
    check("reset_pressed", 32'(prs_a), 32'd0);
    check("reset_connected", 32'(conn_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_clk_latch", {30'd0, clk_a, latch_a}, 32'd0);
    check("reset_state", 32'(dbg_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge cpu_clk);

    // Pad0 A+START, pad1 RIGHT
    poll_a(8'b1111_0110, 8'b0111_1111, 1'b0, 0, 0);
    // Pad0 A, then A+B: B becomes newly pressed
    poll_a(8'b1111_1110, 8'b0111_1111, 1'b0, 0, 0);
    poll_a(8'b1111_1100, 8'b0111_1111, 1'b0, 0, 0);
    // Pad1 line tied low reads as unplugged
    poll_a(8'b1111_1100, 8'b0111_1111, 1'b1, 0, 0);
    // Request mid-poll is dropped with an overrun pulse
    poll_a(8'b1111_0110, 8'b0111_1111, 1'b0, 20, 0);
    // Reset mid-poll aborts and clears, next poll is normal
    poll_a(8'b1111_0110, 8'b0111_1111, 1'b0, 0, 30);
    poll_a(8'b1111_0110, 8'b0111_1111, 1'b0, 0, 0);
    // Random pad contents
    for (int i = 0; i < 3; i++)
      poll_a(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0, 0, 0);

    // SNES: pad0 X+R, pad1 START
    poll_s(16'hF5FF, 16'hFFF7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
